// File: rtl/reorder_buffer_param_if.sv
// Decoder / writeback / commit bundle of the parametrised reorder buffer.
// The slave side is the ROB. The master side is the surrounding core.
interface reorder_buffer_param_if #(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
);
  logic             rdy;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_id;
  logic [XLEN-1:0]  alloc_pc;
  logic [1:0]       alloc_kind;
  logic [4:0]       alloc_rd;
  logic [XLEN-1:0]  alloc_pred_pc;
  logic             wb0_valid;
  logic [IDX_W-1:0] wb0_id;
  logic [XLEN-1:0]  wb0_value;
  logic [XLEN-1:0]  wb0_target;
  logic             wb1_valid;
  logic [IDX_W-1:0] wb1_id;
  logic [XLEN-1:0]  wb1_value;
  logic [XLEN-1:0]  wb1_addr;
  logic [IDX_W-1:0] q_id;
  logic             q_ready;
  logic [XLEN-1:0]  q_value;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_id;
  logic             commit_rd_we;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_value;
  logic             st_valid;
  logic [XLEN-1:0]  st_addr;
  logic [XLEN-1:0]  st_value;
  logic             st_ready;
  logic             pdc_valid;
  logic [XLEN-1:0]  pdc_pc;
  logic             pdc_taken;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;
  logic [IDX_W:0]   count;

  modport master (
    output rdy, alloc_valid, alloc_pc, alloc_kind, alloc_rd, alloc_pred_pc,
           wb0_valid, wb0_id, wb0_value, wb0_target,
           wb1_valid, wb1_id, wb1_value, wb1_addr, q_id, st_ready,
    input  alloc_ready, alloc_id, q_ready, q_value,
           commit_valid, commit_id, commit_rd_we, commit_rd, commit_value,
           st_valid, st_addr, st_value, pdc_valid, pdc_pc, pdc_taken,
           flush, flush_pc, count
  );

  modport slave (
    input  rdy, alloc_valid, alloc_pc, alloc_kind, alloc_rd, alloc_pred_pc,
           wb0_valid, wb0_id, wb0_value, wb0_target,
           wb1_valid, wb1_id, wb1_value, wb1_addr, q_id, st_ready,
    output alloc_ready, alloc_id, q_ready, q_value,
           commit_valid, commit_id, commit_rd_we, commit_rd, commit_value,
           st_valid, st_addr, st_value, pdc_valid, pdc_pc, pdc_taken,
           flush, flush_pc, count
  );
endinterface

// File: rtl/reorder_buffer_param.sv
// In-order-commit reorder buffer with 2**IDX_W entries, two writeback ports,
// a store handshake, an operand lookup with bypass, and single-cycle mispredict flush.
module reorder_buffer_param #(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input logic                  clk,
  input logic                  rst,
  reorder_buffer_param_if.slave bus
);
  localparam int         DEPTH = 1 << IDX_W;
  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_JMP = 2'd3;

  logic [DEPTH-1:0] valid_r, ready_r;
  logic [1:0]       kind_r   [DEPTH];
  logic [4:0]       rd_r     [DEPTH];
  logic [XLEN-1:0]  pc_r     [DEPTH];
  logic [XLEN-1:0]  pred_r   [DEPTH];
  logic [XLEN-1:0]  value_r  [DEPTH];
  logic [XLEN-1:0]  target_r [DEPTH];
  logic [XLEN-1:0]  addr_r   [DEPTH];
  logic [IDX_W-1:0] head_r, tail_r;
  logic [IDX_W:0]   count_r;

  logic             commit_valid_r, commit_rd_we_r, pdc_valid_r, pdc_taken_r, flush_r;
  logic [IDX_W-1:0] commit_id_r;
  logic [4:0]       commit_rd_r;
  logic [XLEN-1:0]  commit_value_r, pdc_pc_r, flush_pc_r;

  logic             full_s, empty_s, alloc_ready_s, alloc_fire_s, wb_en_s;
  logic             wb0_hit_s, wb1_hit_s, head_ready_s, head_is_br_s;
  logic             st_valid_s, commit_fire_s, mispredict_s, q_ready_s;
  logic [1:0]       head_kind_s;
  logic [XLEN-1:0]  q_value_s;

  assign full_s        = (count_r == (IDX_W+1)'(DEPTH));
  assign empty_s       = (count_r == (IDX_W+1)'(0));
  assign alloc_ready_s = !full_s && !flush_r;
  assign alloc_fire_s  = bus.alloc_valid && alloc_ready_s && bus.rdy;
  assign wb_en_s       = bus.rdy && !flush_r;
  // Writebacks only land on live entries; stale ids from a flushed window drop out here.
  assign wb0_hit_s     = wb_en_s && bus.wb0_valid && valid_r[bus.wb0_id];
  assign wb1_hit_s     = wb_en_s && bus.wb1_valid && valid_r[bus.wb1_id];
  assign head_kind_s   = kind_r[head_r];
  assign head_ready_s  = valid_r[head_r] && ready_r[head_r];
  assign head_is_br_s  = (head_kind_s == K_BR) || (head_kind_s == K_JMP);
  assign st_valid_s    = bus.rdy && !empty_s && !flush_r && head_ready_s && (head_kind_s == K_ST);
  assign commit_fire_s = bus.rdy && !empty_s && !flush_r && head_ready_s &&
                         ((head_kind_s != K_ST) || bus.st_ready);
  assign mispredict_s  = commit_fire_s && head_is_br_s && (target_r[head_r] != pred_r[head_r]);

  // Operand lookup: same-cycle writebacks bypass the stored entry, wb0 first.
  always_comb begin
    q_ready_s = 1'b0;
    q_value_s = '0;
    if (wb0_hit_s && (bus.wb0_id == bus.q_id)) begin
      q_ready_s = 1'b1;
      q_value_s = bus.wb0_value;
    end else if (wb1_hit_s && (bus.wb1_id == bus.q_id)) begin
      q_ready_s = 1'b1;
      q_value_s = bus.wb1_value;
    end else if (valid_r[bus.q_id] && ready_r[bus.q_id]) begin
      q_ready_s = 1'b1;
      q_value_s = value_r[bus.q_id];
    end else begin
      q_ready_s = 1'b0;
      q_value_s = '0;
    end
  end

  // Pointers, occupancy, entry status bits and registered commit/predictor/flush pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      valid_r        <= '0;
      ready_r        <= '0;
      commit_valid_r <= 1'b0;
      commit_id_r    <= '0;
      commit_rd_we_r <= 1'b0;
      commit_rd_r    <= 5'd0;
      commit_value_r <= '0;
      pdc_valid_r    <= 1'b0;
      pdc_pc_r       <= '0;
      pdc_taken_r    <= 1'b0;
      flush_r        <= 1'b0;
      flush_pc_r     <= '0;
    end else begin
      commit_valid_r <= commit_fire_s;
      pdc_valid_r    <= commit_fire_s && head_is_br_s;
      flush_r        <= mispredict_s;
      if (commit_fire_s) begin
        commit_id_r    <= head_r;
        commit_rd_we_r <= ((head_kind_s == K_REG) || (head_kind_s == K_JMP)) && (rd_r[head_r] != 5'd0);
        commit_rd_r    <= rd_r[head_r];
        commit_value_r <= value_r[head_r];
        pdc_pc_r       <= pc_r[head_r];
        pdc_taken_r    <= (target_r[head_r] != (pc_r[head_r] + XLEN'(4)));
      end
      if (mispredict_s) begin
        flush_pc_r <= target_r[head_r];
        head_r     <= '0;
        tail_r     <= '0;
        count_r    <= '0;
        valid_r    <= '0;
        ready_r    <= '0;
      end else begin
        if (alloc_fire_s) begin
          valid_r[tail_r] <= 1'b1;
          ready_r[tail_r] <= 1'b0;
          tail_r          <= tail_r + IDX_W'(1);
        end
        if (wb1_hit_s) ready_r[bus.wb1_id] <= 1'b1;
        if (wb0_hit_s) ready_r[bus.wb0_id] <= 1'b1;
        if (commit_fire_s) begin
          valid_r[head_r] <= 1'b0;
          ready_r[head_r] <= 1'b0;
          head_r          <= head_r + IDX_W'(1);
        end
        case ({alloc_fire_s, commit_fire_s})
          2'b10:   count_r <= count_r + (IDX_W+1)'(1);
          2'b01:   count_r <= count_r - (IDX_W+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Entry payload. Unreset, because a slot is never read before its valid/ready bits are set.
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      kind_r[tail_r] <= bus.alloc_kind;
      rd_r[tail_r]   <= bus.alloc_rd;
      pc_r[tail_r]   <= bus.alloc_pc;
      pred_r[tail_r] <= bus.alloc_pred_pc;
    end
    if (wb1_hit_s) begin
      value_r[bus.wb1_id] <= bus.wb1_value;
      addr_r[bus.wb1_id]  <= bus.wb1_addr;
    end
    if (wb0_hit_s) begin
      value_r[bus.wb0_id]  <= bus.wb0_value;
      target_r[bus.wb0_id] <= bus.wb0_target;
    end
  end

  assign bus.alloc_ready  = alloc_ready_s;
  assign bus.alloc_id     = tail_r;
  assign bus.q_ready      = q_ready_s;
  assign bus.q_value      = q_value_s;
  assign bus.st_valid     = st_valid_s;
  assign bus.st_addr      = st_valid_s ? addr_r[head_r] : '0;
  assign bus.st_value     = st_valid_s ? value_r[head_r] : '0;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_id    = commit_id_r;
  assign bus.commit_rd_we = commit_rd_we_r;
  assign bus.commit_rd    = commit_rd_r;
  assign bus.commit_value = commit_value_r;
  assign bus.pdc_valid    = pdc_valid_r;
  assign bus.pdc_pc       = pdc_pc_r;
  assign bus.pdc_taken    = pdc_taken_r;
  assign bus.flush        = flush_r;
  assign bus.flush_pc     = flush_pc_r;
  assign bus.count        = count_r;
endmodule
